// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: reader-side front end of the 8x16 register file.
//   Accepts decoded instructions over valid/ready and drives the RF read ports.
//   Scoreboards in-flight destinations and stalls on read-after-write hazards.
//   Presents registered operands plus control to execute, one cycle after accept.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready, in_src1, in_src2, in_use_src2, in_dst, in_dst_en, in_ctrl
//   rf_read_addr_1/2 (out), rf_read_data_1/2 (in)
//   wb_en, wb_addr, wb_data (write-back snoop)
//   out_valid/out_ready, out_op1, out_op2, out_dst, out_dst_en, out_ctrl
//   busy (scoreboard, bit i = register i has a pending write)
// Options:
//   OFU_BYPASS_EN: when defined, same-cycle write-back data is forwarded
//   into the operands so a dependent instruction issues in the wb cycle.
module operand_fetch_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8,
    parameter int CTRL_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_src1,
    input  logic [ADDR_W-1:0]   in_src2,
    input  logic                in_use_src2,
    input  logic [ADDR_W-1:0]   in_dst,
    input  logic                in_dst_en,
    input  logic [CTRL_W-1:0]   in_ctrl,
    output logic [ADDR_W-1:0]   rf_read_addr_1,
    output logic [ADDR_W-1:0]   rf_read_addr_2,
    input  logic [DATA_W-1:0]   rf_read_data_1,
    input  logic [DATA_W-1:0]   rf_read_data_2,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_op1,
    output logic [DATA_W-1:0]   out_op2,
    output logic [ADDR_W-1:0]   out_dst,
    output logic                out_dst_en,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                valid_q;
    logic [DATA_W-1:0]   op1_q, op2_q;
    logic [ADDR_W-1:0]   dst_q;
    logic                dst_en_q;
    logic [CTRL_W-1:0]   ctrl_q;

    logic                fwd1, fwd2;
    logic                haz1, haz2;
    logic                accept;
    logic [DATA_W-1:0]   op1_d, op2_d;

    assign rf_read_addr_1 = in_src1;
    assign rf_read_addr_2 = in_src2;

`ifdef OFU_BYPASS_EN
    assign fwd1 = wb_en && (wb_addr == in_src1);
    assign fwd2 = wb_en && (wb_addr == in_src2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // A forwarded source is satisfied this cycle even though busy is still set.
    assign haz1 = busy_q[in_src1] && !fwd1;
    assign haz2 = in_use_src2 && busy_q[in_src2] && !fwd2;

    assign in_ready = (!valid_q || out_ready) && !haz1 && !haz2;
    assign accept   = in_valid && in_ready;

    assign op1_d = fwd1 ? wb_data : rf_read_data_1;
    assign op2_d = !in_use_src2 ? '0 :
                   fwd2 ? wb_data : rf_read_data_2;

    // Clear on write-back first so a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (accept && in_dst_en) begin
            busy_d[in_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            valid_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            dst_q    <= '0;
            dst_en_q <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            busy_q <= busy_d;
            if (accept) begin
                valid_q  <= 1'b1;
                op1_q    <= op1_d;
                op2_q    <= op2_d;
                dst_q    <= in_dst;
                dst_en_q <= in_dst_en;
                ctrl_q   <= in_ctrl;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_op1    = op1_q;
    assign out_op2    = op2_q;
    assign out_dst    = dst_q;
    assign out_dst_en = dst_en_q;
    assign out_ctrl   = ctrl_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb_operand_fetch_unit: directed vector table plus randomized traffic
//   checked against a cycle-level behavioural model of the fetch unit.
module tb_operand_fetch_unit;

`ifdef OFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int D = -1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_src1, in_src2, in_dst;
    logic        in_use_src2, in_dst_en;
    logic [7:0]  in_ctrl;
    logic [2:0]  rf_read_addr_1, rf_read_addr_2;
    logic [15:0] rf_read_data_1, rf_read_data_2;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid, out_ready;
    logic [15:0] out_op1, out_op2;
    logic [2:0]  out_dst;
    logic        out_dst_en;
    logic [7:0]  out_ctrl;
    logic [7:0]  busy;

    operand_fetch_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2),
        .in_use_src2(in_use_src2),
        .in_dst(in_dst), .in_dst_en(in_dst_en),
        .in_ctrl(in_ctrl),
        .rf_read_addr_1(rf_read_addr_1),
        .rf_read_addr_2(rf_read_addr_2),
        .rf_read_data_1(rf_read_data_1),
        .rf_read_data_2(rf_read_data_2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_dst(out_dst), .out_dst_en(out_dst_en),
        .out_ctrl(out_ctrl), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file environment: async read, write on wb_en, known contents on rst.
    logic [15:0] rf_mem [8];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 16'(16'h1111 * i);
        end else if (wb_en) begin
            rf_mem[wb_addr] <= wb_data;
        end
    end
    always_comb rf_read_data_1 = rf_mem[rf_read_addr_1];
    always_comb rf_read_data_2 = rf_mem[rf_read_addr_2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending-write set plus one output slot.
    bit        m_known = 0;
    bit        pend [8];
    bit        m_v;
    bit [15:0] m_op1, m_op2;
    bit [2:0]  m_dst;
    bit        m_dst_en;
    bit [7:0]  m_ctrl;

    function automatic bit fwd_ok(input logic [2:0] s);
        return BYP && wb_en && (wb_addr == s);
    endfunction

    task automatic model_step();
        bit        hz;
        bit        rdy;
        bit [7:0]  pv;
        bit [15:0] o1, o2;
        hz = pend[in_src1] && !fwd_ok(in_src1);
        if (in_use_src2 && pend[in_src2] && !fwd_ok(in_src2)) hz = 1;
        rdy = (!m_v || out_ready) && !hz;
        for (int i = 0; i < 8; i++) pv[i] = pend[i];
        if (m_known) begin
            chk("in_ready", in_ready, rdy);
            chk("out_valid", out_valid, m_v);
            chk("busy", busy, pv);
            chk("raddr1", rf_read_addr_1, in_src1);
            chk("raddr2", rf_read_addr_2, in_src2);
            if (m_v) begin
                chk("op1", out_op1, m_op1);
                chk("op2", out_op2, m_op2);
                chk("dst", {out_dst_en, out_dst}, {m_dst_en, m_dst});
                chk("ctrl", out_ctrl, m_ctrl);
            end
        end
        if (rst) begin
            m_known = 1;
            for (int i = 0; i < 8; i++) pend[i] = 0;
            m_v = 0; m_op1 = 0; m_op2 = 0;
            m_dst = 0; m_dst_en = 0; m_ctrl = 0;
        end else if (m_known) begin
            o1 = fwd_ok(in_src1) ? wb_data : rf_mem[in_src1];
            o2 = !in_use_src2 ? 16'h0 :
                 fwd_ok(in_src2) ? wb_data : rf_mem[in_src2];
            if (wb_en) pend[wb_addr] = 0;
            if (in_valid && rdy) begin
                m_v = 1; m_op1 = o1; m_op2 = o2;
                m_dst = in_dst; m_dst_en = in_dst_en; m_ctrl = in_ctrl;
                if (in_dst_en) pend[in_dst] = 1;
            end else if (out_ready) begin
                m_v = 0;
            end
        end
    endtask

    typedef struct {
        bit        rs, v, u2, de, we, ordy;
        bit [2:0]  s1, s2, d, wa;
        bit [15:0] wd;
        int        er, ev, eo1, eo2, eb;
    } row_t;

    function automatic row_t mk(bit rs, bit v, int s1, int s2, bit u2,
                                int d, bit de, bit we, int wa, int wd,
                                bit ordy, int er, int ev, int eo1,
                                int eo2, int eb);
        row_t r;
        r.rs = rs; r.v = v; r.s1 = 3'(s1); r.s2 = 3'(s2); r.u2 = u2;
        r.d = 3'(d); r.de = de; r.we = we; r.wa = 3'(wa);
        r.wd = 16'(wd); r.ordy = ordy;
        r.er = er; r.ev = ev; r.eo1 = eo1; r.eo2 = eo2; r.eb = eb;
        return r;
    endfunction

    row_t tbl[$];

    initial begin
        int k;
        int byp_i;
        int pq[$];
        byp_i = int'(BYP);
        rst = 1; in_valid = 0; in_src1 = 0; in_src2 = 0;
        in_use_src2 = 0; in_dst = 0; in_dst_en = 0; in_ctrl = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;

        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1, D,D,D,D,D));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,1, D,D,D,D,D));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1, 1,0,0,0,0));
        tbl.push_back(mk(0,1,1,2,1,0,0,0,0,0,1, 1,0,D,D,0));
        tbl.push_back(mk(0,1,0,0,0,3,1,0,0,0,1,
                         1,1,'h1111,'h2222,0));
        tbl.push_back(mk(0,1,3,0,0,0,0,0,0,0,1, 0,1,0,0,'h08));
        tbl.push_back(mk(0,1,3,0,0,0,0,0,0,0,1, 0,0,D,D,'h08));
        tbl.push_back(mk(0,1,3,0,0,0,0,1,3,'hBEEF,1,
                         byp_i,0,D,D,'h08));
        tbl.push_back(mk(0,1,3,0,0,0,0,0,0,0,1, 1,byp_i,D,D,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1, 1,1,'hBEEF,0,0));
        tbl.push_back(mk(0,1,1,2,1,4,0,0,0,0,1, 1,0,D,D,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,2,1,1,4,0,0,0,0,0,
                             0,1,'h1111,'h2222,0));
        tbl.push_back(mk(0,1,2,1,1,4,0,0,0,0,1,
                         1,1,'h1111,'h2222,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,
                         1,1,'h2222,'h1111,0));
        tbl.push_back(mk(0,1,0,0,0,5,1,1,5,'h5A5A,1, 1,0,D,D,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1, 1,1,0,0,'h20));
        tbl.push_back(mk(0,1,1,5,0,0,0,0,0,0,1, 1,0,D,D,'h20));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,
                         1,1,'h1111,0,'h20));
        for (int j = 0; j < 8; j++) begin
            if (j != 5)
                tbl.push_back(mk(0,1,j,0,0,j,1,0,0,0,1, 1,D,D,D,D));
        end
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,1, 0,1,D,D,'hFF));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0,0,1, D,D,D,D,D));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,1, 1,0,D,D,0));

        k = 0;
        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rs; in_valid = tbl[i].v;
            in_src1 = tbl[i].s1; in_src2 = tbl[i].s2;
            in_use_src2 = tbl[i].u2;
            in_dst = tbl[i].d; in_dst_en = tbl[i].de;
            in_ctrl = 8'(8'h30 + i);
            wb_en = tbl[i].we; wb_addr = tbl[i].wa;
            wb_data = tbl[i].wd; out_ready = tbl[i].ordy;
            #1;
            if (tbl[i].er >= 0)
                chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].er);
            if (tbl[i].ev >= 0)
                chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            if (tbl[i].eo1 >= 0)
                chk($sformatf("tbl%0d_op1", i), out_op1, tbl[i].eo1);
            if (tbl[i].eo2 >= 0)
                chk($sformatf("tbl%0d_op2", i), out_op2, tbl[i].eo2);
            if (tbl[i].eb >= 0)
                chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
            model_step();
            k++;
        end

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_src1 = 3'($urandom);
            in_src2 = 3'($urandom);
            in_use_src2 = 1'($urandom);
            in_dst = 3'($urandom);
            in_dst_en = 1'($urandom);
            in_ctrl = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en = ($urandom_range(0, 9) < 4);
            pq.delete();
            for (int i = 0; i < 8; i++) if (pend[i]) pq.push_back(i);
            if (pq.size() > 0 && $urandom_range(0, 3) != 0)
                wb_addr = 3'(pq[$urandom_range(0, pq.size() - 1)]);
            else
                wb_addr = 3'($urandom);
            wb_data = 16'($urandom);
            #1;
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Reader-side companion to the 8x16 general-purpose register file.
- Accepts decoded instructions (src1/src2/dst) over a valid/ready handshake and drives the file's two asynchronous read-address ports.
- Tracks in-flight destination registers in a scoreboard and stalls on read-after-write hazards, forwarding same-cycle write-back data where enabled.
- Presents registered operands plus pass-through control to the execute stage, one cycle after acceptance.

Parameters:
- DATA_W, 16, register/operand width
- ADDR_W, 3, register address width
- NUM_REGS, 8, register count (equals 2**ADDR_W)
- CTRL_W, 8, opaque control bits passed through to execute

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  decoded instruction present
- in_ready  output  1  instruction accepted this cycle when in_valid && in_ready
- in_src1  input  ADDR_W  first source register
- in_src2  input  ADDR_W  second source register
- in_use_src2  input  1  src2 is a real operand; otherwise ignored for hazards
- in_dst  input  ADDR_W  destination register
- in_dst_en  input  1  instruction will write in_dst
- in_ctrl  input  CTRL_W  pass-through control
- rf_read_addr_1  output  ADDR_W  to register file read address 1
- rf_read_addr_2  output  ADDR_W  to register file read address 2
- rf_read_data_1  input  DATA_W  from register file read data 1
- rf_read_data_2  input  DATA_W  from register file read data 2
- wb_en  input  1  write-back strobe, same signal as register file write enable
- wb_addr  input  ADDR_W  write-back address
- wb_data  input  DATA_W  write-back data
- out_valid  output  1  operands valid to execute
- out_ready  input  1  execute consumes when out_valid && out_ready
- out_op1  output  DATA_W  operand 1
- out_op2  output  DATA_W  operand 2 (0 when use_src2 was 0)
- out_dst  output  ADDR_W  registered destination
- out_dst_en  output  1  registered destination enable
- out_ctrl  output  CTRL_W  registered control
- busy  output  NUM_REGS  scoreboard, bit i = register i has a pending write

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: out_valid=0; out_op1/out_op2/out_dst/out_ctrl=0; out_dst_en=0; busy=0. Reset mid-stall drops the held instruction and clears all pending marks.
- Read addresses: rf_read_addr_1=in_src1 and rf_read_addr_2=in_src2, combinational at all times.
- Hazard, per used source s: busy[s] && !fwd(s).
  - With bypass: fwd(s) = wb_en && wb_addr==s.
  - Without bypass: fwd(s) = 0.
- in_ready = (!out_valid || out_ready) && !hazard. in_ready may depend on in_* payload and state, never on in_valid.
- Operand select with bypass: wb_data when wb_en && wb_addr==src, else rf_read_data. Without bypass: always rf_read_data.
- On accept:
  - Output registers load next edge; out_valid=1. Latency is exactly 1 cycle.
  - If in_dst_en, busy[in_dst] is set.
- Output hold: while out_valid && !out_ready, all out_* are stable and in_ready=0.
- Output drain: out_valid falls when it is consumed with no new accept in the same cycle.
- Scoreboard:
  - wb_en clears busy[wb_addr].
  - If an accept sets the same address in the same cycle, set wins.
  - wb_en to a non-busy register is legal and leaves busy unchanged.
- Self-dependency (src==dst, busy clear) issues normally and reads the old value.
- Back-to-back dependent instructions: the second stalls until write-back of the first.

Optional Feature:
- Macro: OFU_BYPASS_EN.
- Defined: same-cycle write-back forwarding as above; a dependent instruction issues in the write-back cycle.
- Undefined: no forwarding. Issue waits until busy clears, one cycle after wb_en, and operands are read from the register file after the write has landed. Costs 1 stall cycle per dependency.

Test Plan:
- Reset, then in_valid with src1=1, src2=2, use_src2=1, dst_en=0, RF data 0x1111/0x2222 -> next cycle out_valid=1, out_op1=0x1111, out_op2=0x2222; busy=0x00.
- Accept dst=3, dst_en=1; next instruction src1=3 -> in_ready=0 while busy=0x08. wb_en, wb_addr=3, wb_data=0xBEEF:
  - With bypass: accept that cycle, out_op1=0xBEEF.
  - Without bypass: accept one cycle later, out_op1=0xBEEF from RF.
- out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; out_ready=1 plus pending in_valid -> new data next cycle with no bubble.
- Same cycle: accept dst_en=1 dst=5 and wb_en wb_addr=5 -> busy[5]=1 afterwards.
- use_src2=0 with busy[src2]=1 -> no stall, out_op2=0.
- rst asserted while stalled with busy=0xFF -> next cycle busy=0, out_valid=0, in_ready=1.
